// File: rtl/key_scan_pkg.sv
// Shared register map, bit positions and event layout for the key event scanner.
// Both the top level and the bench-visible register decode use these names.
package key_scan_pkg;

  typedef enum logic [2:0] {
    REG_STATUS  = 3'd0,
    REG_CONTROL = 3'd1,
    REG_PERIOD  = 3'd2,
    REG_EVENT   = 3'd3,
    REG_KEYS    = 3'd4,
    REG_RAW     = 3'd5
  } reg_addr_e;

  localparam int CTRL_IRQ_EN  = 0;
  localparam int CTRL_SCAN_EN = 1;

  localparam int STAT_NONEMPTY  = 0;
  localparam int STAT_OVERFLOW  = 1;
  localparam int STAT_COUNT_LSB = 4;
  localparam int STAT_COUNT_W   = 4;

  localparam int EVT_VALID_BIT = 15;
  localparam int EVT_PRESS_BIT = 8;
  localparam int EVT_KEY_W     = 4;

  // Smallest tick period; long enough for a full 16-key mask to drain between ticks.
  localparam logic [15:0] PERIOD_MIN = 16'd32;

  function automatic logic [15:0] make_event(input logic press, input logic [EVT_KEY_W-1:0] key);
    logic [15:0] ev;
    ev                = '0;
    ev[EVT_VALID_BIT] = 1'b1;
    ev[EVT_PRESS_BIT] = press;
    ev[EVT_KEY_W-1:0] = key;
    return ev;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Synchronous event queue with occupancy count; a push into a full queue is
// accepted only when a pop happens in the same cycle.
module key_event_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign pop_data = empty ? '0 : mem[rd_ptr];

  // NOTE: storage carries no reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/key_event_scanner.sv
// Debounced key scanner: samples synchronized keys on a programmable tick and
// queues press/release events for an Avalon-MM host, with a level interrupt.
module key_event_scanner
  import key_scan_pkg::*;
#(
  parameter int NKEYS          = 16,
  parameter int DEPTH          = 8,
  parameter int DEFAULT_PERIOD = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NKEYS-1:0] keys_in,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic             read_n,
  input  logic [15:0]      writedata,
  output logic [15:0]      readdata,
  output logic             irq
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [NKEYS-1:0] keys_meta, keys_sync;
  logic [NKEYS-1:0] sample_q, deb_q, mask_q;
  logic [NKEYS-1:0] change, lsb_onehot;
  logic [3:0]       lsb_idx;
  logic [15:0]      tick_cnt_q, period_q, period_clamped;
  logic [1:0]       ctrl_q;
  logic             overflow_q;
  logic             tick, wr_en, rd_en, period_wr, status_wr;
  logic             ev_push, ev_pop;
  logic [15:0]      ev_data, fifo_head, status_word, rd_mux;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // NOTE: non-blocking assignments make the two stages shift one per clock instead of collapsing.
  always_ff @(posedge clk) begin
    if (reset) begin
      keys_meta <= '0;
      keys_sync <= '0;
    end else begin
      keys_meta <= keys_in;
      keys_sync <= keys_meta;
    end
  end

  assign wr_en          = chipselect & ~write_n;
  assign rd_en          = chipselect & ~read_n;
  assign period_wr      = wr_en && (address == REG_PERIOD);
  assign status_wr      = wr_en && (address == REG_STATUS);
  assign ev_pop         = rd_en && (address == REG_EVENT);
  assign period_clamped = (writedata < PERIOD_MIN) ? PERIOD_MIN : writedata;

  assign tick = ctrl_q[CTRL_SCAN_EN] && (tick_cnt_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= 16'(DEFAULT_PERIOD);
      period_q   <= 16'(DEFAULT_PERIOD);
      ctrl_q     <= '0;
    end else begin
      if (wr_en && (address == REG_CONTROL)) ctrl_q <= writedata[1:0];
      if (period_wr) begin
        period_q   <= period_clamped;
        tick_cnt_q <= period_clamped;
      end else if (ctrl_q[CTRL_SCAN_EN]) begin
        tick_cnt_q <= tick ? period_q : tick_cnt_q - 16'd1;
      end
    end
  end

  // A key flips only after two consecutive identical samples that disagree with its debounced state.
  assign change = ~(keys_sync ^ sample_q) & (keys_sync ^ deb_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q <= '0;
      deb_q    <= '0;
      mask_q   <= '0;
    end else begin
      if (tick) begin
        sample_q <= keys_sync;
        deb_q    <= deb_q ^ change;
      end
      mask_q <= (mask_q & ~lsb_onehot) | (tick ? change : '0);
    end
  end

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    lsb_idx    = '0;
    lsb_onehot = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        lsb_idx       = 4'(i);
        lsb_onehot    = '0;
        lsb_onehot[i] = 1'b1;
      end
    end
  end

  assign ev_push = |mask_q;
  assign ev_data = make_event(|(deb_q & lsb_onehot), lsb_idx);

  key_event_fifo #(
    .WIDTH (16),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (ev_push),
    .push_data (ev_data),
    .pop       (ev_pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A drop sets overflow even if software clears it in the same cycle.
  always_ff @(posedge clk) begin
    if (reset)                                 overflow_q <= 1'b0;
    else if (ev_push && fifo_full && !ev_pop)  overflow_q <= 1'b1;
    else if (status_wr)                        overflow_q <= 1'b0;
  end

  always_comb begin
    status_word                                = '0;
    status_word[STAT_NONEMPTY]                 = ~fifo_empty;
    status_word[STAT_OVERFLOW]                 = overflow_q;
    status_word[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      REG_STATUS:  rd_mux = status_word;
      REG_CONTROL: rd_mux = {14'd0, ctrl_q};
      REG_PERIOD:  rd_mux = period_q;
      REG_EVENT:   rd_mux = fifo_head;
      REG_KEYS:    rd_mux = 16'(deb_q);
      REG_RAW:     rd_mux = 16'(keys_sync);
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_mux;
  end

  assign irq = ctrl_q[CTRL_IRQ_EN] & (~fifo_empty | overflow_q);

endmodule

// File: tb/tb_key_event_scanner.sv
// Self-checking bench for key_event_scanner: directed scenarios plus randomized
// key activity checked against a per-step event-queue model.
module tb_key_event_scanner;

  localparam int NKEYS          = 16;
  localparam int DEPTH          = 8;
  localparam int DEFAULT_PERIOD = 50000;

  localparam logic [2:0] A_STATUS  = 3'd0;
  localparam logic [2:0] A_CONTROL = 3'd1;
  localparam logic [2:0] A_PERIOD  = 3'd2;
  localparam logic [2:0] A_EVENT   = 3'd3;
  localparam logic [2:0] A_KEYS    = 3'd4;
  localparam logic [2:0] A_RAW     = 3'd5;

  logic             clk = 1'b0;
  logic             reset;
  logic [NKEYS-1:0] keys_in;
  logic [2:0]       address;
  logic             chipselect, write_n, read_n;
  logic [15:0]      writedata, readdata;
  logic             irq;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic [15:0] cur, nxt, flip, ev, exp_status;
  bit          ovf, found, do_glitch;
  int          c1, c2, c3, gk, glen;

  always #5 clk = ~clk;

  key_event_scanner #(
    .NKEYS          (NKEYS),
    .DEPTH          (DEPTH),
    .DEFAULT_PERIOD (DEFAULT_PERIOD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .keys_in    (keys_in),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .read_n     (read_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    @(negedge clk);
    d = readdata;
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic read_check(input string tag, input logic [2:0] a, input logic [15:0] exp);
    logic [15:0] d;
    bus_read(a, d);
    check(tag, {16'h0, d}, {16'h0, exp});
  endtask

  task automatic apply_reset();
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
    idle_cycles(3);
    reset = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; keys_in = '0; address = '0; chipselect = 1'b0;
    write_n = 1'b1; read_n = 1'b1; writedata = '0;
    @(negedge clk);

    // Reset state
    apply_reset();
    check("rst_readdata", {16'h0, readdata}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    read_check("rst_control", A_CONTROL, 16'h0000);
    read_check("rst_period", A_PERIOD, 16'(DEFAULT_PERIOD));
    read_check("rst_status", A_STATUS, 16'h0000);
    read_check("rst_keys", A_KEYS, 16'h0000);
    read_check("rst_raw", A_RAW, 16'h0000);
    read_check("rst_addr6", 3'd6, 16'h0000);
    read_check("rst_addr7", 3'd7, 16'h0000);
    read_check("rst_event_empty", A_EVENT, 16'h0000);

    // Single press of key 5
    bus_write(A_PERIOD, 16'd32);
    bus_write(A_CONTROL, 16'h0002);
    keys_in = 16'h0020;
    idle_cycles(100);
    read_check("k5_keys", A_KEYS, 16'h0020);
    read_check("k5_event", A_EVENT, 16'h8105);
    read_check("k5_status_after", A_STATUS, 16'h0000);

    // Short glitch is rejected
    apply_reset();
    keys_in = '0;
    bus_write(A_PERIOD, 16'd64);
    bus_write(A_CONTROL, 16'h0002);
    keys_in[2] = 1'b1;
    idle_cycles(20);
    keys_in[2] = 1'b0;
    idle_cycles(200);
    read_check("glitch_keys", A_KEYS, 16'h0000);
    read_check("glitch_status", A_STATUS, 16'h0000);

    // Three simultaneous presses drain on consecutive cycles in index order
    apply_reset();
    keys_in = '0;
    bus_write(A_PERIOD, 16'd32);
    bus_write(A_CONTROL, 16'h0002);
    address = A_STATUS; chipselect = 1'b1; read_n = 1'b0;
    keys_in = 16'h0209;
    c1 = -1; c2 = -1; c3 = -1;
    for (int cyc = 0; cyc < 300 && c3 < 0; cyc++) begin
      @(negedge clk);
      if (readdata[7:4] == 4'd1 && c1 < 0) c1 = cyc;
      if (readdata[7:4] == 4'd2 && c2 < 0) c2 = cyc;
      if (readdata[7:4] == 4'd3 && c3 < 0) c3 = cyc;
    end
    chipselect = 1'b0; read_n = 1'b1;
    check("multi_gap_1_2", c2 - c1, 1);
    check("multi_gap_2_3", c3 - c2, 1);
    read_check("multi_ev0", A_EVENT, 16'h8100);
    read_check("multi_ev3", A_EVENT, 16'h8103);
    read_check("multi_ev9", A_EVENT, 16'h8109);

    // Nine events with no reads: overflow, irq, clear
    apply_reset();
    keys_in = '0;
    bus_write(A_PERIOD, 16'd32);
    bus_write(A_CONTROL, 16'h0002);
    keys_in = 16'h01FF;
    idle_cycles(100);
    bus_write(A_CONTROL, 16'h0001);
    check("ovf_irq", {31'h0, irq}, 32'h1);
    read_check("ovf_status", A_STATUS, 16'h0083);
    bus_write(A_STATUS, 16'hFFFF);
    read_check("ovf_cleared", A_STATUS, 16'h0081);
    for (int i = 0; i < 8; i++) read_check("ovf_drain", A_EVENT, 16'h8100 | 16'(i));
    read_check("ovf_empty_read", A_EVENT, 16'h0000);
    read_check("ovf_empty_status", A_STATUS, 16'h0000);
    check("ovf_irq_low", {31'h0, irq}, 32'h0);

    // Pop while full in the same cycle as a push
    apply_reset();
    keys_in = '0;
    bus_write(A_PERIOD, 16'd32);
    bus_write(A_CONTROL, 16'h0002);
    address = A_STATUS; chipselect = 1'b1; read_n = 1'b0;
    keys_in = 16'h01FF;
    found = 1'b0;
    for (int cyc = 0; cyc < 300 && !found; cyc++) begin
      @(negedge clk);
      if (readdata[7:4] == 4'd7) found = 1'b1;
    end
    if (found) begin
      address = A_EVENT;
      @(negedge clk);
      address = A_STATUS;
      chipselect = 1'b0; read_n = 1'b1;
      check("full_pushpop_oldest", {16'h0, readdata}, 32'h8100);
    end
    chipselect = 1'b0; read_n = 1'b1;
    check("full_pushpop_found", {31'h0, found}, 32'h1);
    idle_cycles(5);
    read_check("full_pushpop_status", A_STATUS, 16'h0081);
    for (int i = 1; i < 9; i++) read_check("full_pushpop_drain", A_EVENT, 16'h8100 | 16'(i));

    // Period clamp and reset mid-drain
    apply_reset();
    keys_in = '0;
    bus_write(A_PERIOD, 16'd5);
    read_check("period_clamp_5", A_PERIOD, 16'd32);
    bus_write(A_PERIOD, 16'd31);
    read_check("period_clamp_31", A_PERIOD, 16'd32);
    bus_write(A_PERIOD, 16'd33);
    read_check("period_33", A_PERIOD, 16'd33);
    bus_write(A_CONTROL, 16'h0003);
    address = A_STATUS; chipselect = 1'b1; read_n = 1'b0;
    keys_in = 16'hFFFF;
    found = 1'b0;
    for (int cyc = 0; cyc < 300 && !found; cyc++) begin
      @(negedge clk);
      if (readdata[7:4] >= 4'd2) found = 1'b1;
    end
    check("middrain_found", {31'h0, found}, 32'h1);
    check("middrain_irq_before", {31'h0, irq}, 32'h1);
    reset = 1'b1; chipselect = 1'b0; read_n = 1'b1;
    @(negedge clk);
    check("middrain_readdata", {16'h0, readdata}, 32'h0);
    check("middrain_irq", {31'h0, irq}, 32'h0);
    reset = 1'b0;
    idle_cycles(40);
    bus_write(A_CONTROL, 16'h0001);
    check("middrain_irq_en", {31'h0, irq}, 32'h0);
    read_check("middrain_status", A_STATUS, 16'h0000);
    read_check("middrain_keys", A_KEYS, 16'h0000);
    read_check("middrain_raw", A_RAW, 16'hFFFF);

    // Randomized key activity against the event-queue model
    keys_in = '0;
    apply_reset();
    bus_write(A_PERIOD, 16'd32);
    bus_write(A_CONTROL, 16'h0003);
    cur = '0; ovf = 1'b0; exp_q.delete();
    for (int step = 0; step < 30; step++) begin
      if ($urandom_range(0, 5) == 0) flip = 16'($urandom);
      else flip = (16'(1) << $urandom_range(0, 15)) |
                  (($urandom_range(0, 1) == 1) ? (16'(1) << $urandom_range(0, 15)) : 16'h0);
      nxt  = cur ^ flip;
      gk   = int'($urandom_range(0, 15));
      glen = int'($urandom_range(1, 20));
      do_glitch = !flip[gk] && ($urandom_range(0, 1) == 1);
      keys_in = nxt;
      idle_cycles(5);
      if (do_glitch) begin
        keys_in[gk] = ~keys_in[gk];
        idle_cycles(glen);
        keys_in[gk] = ~keys_in[gk];
      end
      idle_cycles(115);

      for (int i = 0; i < NKEYS; i++) begin
        if (flip[i]) begin
          ev = 16'h8000 | (nxt[i] ? 16'h0100 : 16'h0000) | 16'(i);
          if (exp_q.size() < DEPTH) exp_q.push_back(ev);
          else ovf = 1'b1;
        end
      end
      cur = nxt;

      check("rand_irq", {31'h0, irq}, {31'h0, (exp_q.size() > 0) || ovf});
      read_check("rand_keys", A_KEYS, cur);
      read_check("rand_raw", A_RAW, cur);
      if ($urandom_range(0, 2) != 0) begin
        exp_status = (16'(exp_q.size()) << 4) | (ovf ? 16'h0002 : 16'h0000) |
                     ((exp_q.size() != 0) ? 16'h0001 : 16'h0000);
        read_check("rand_status", A_STATUS, exp_status);
        while (exp_q.size() > 0) read_check("rand_event", A_EVENT, exp_q.pop_front());
        if (ovf) begin
          bus_write(A_STATUS, 16'h0000);
          ovf = 1'b0;
        end
        read_check("rand_status_drained", A_STATUS, 16'h0000);
      end
    end
    while (exp_q.size() > 0) read_check("final_event", A_EVENT, exp_q.pop_front());
    read_check("final_empty_event", A_EVENT, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_event_scanner.md
KEY_EVENT_SCANNER -- requirements
Module: key_event_scanner

Interface
REQ-001 SHALL have parameter NKEYS, default 16, the number of piano key inputs.
REQ-002 SHALL have parameter DEPTH, default 8, the event FIFO depth in entries.
REQ-003 SHALL have parameter DEFAULT_PERIOD, default 50000, the reset debounce tick period in clk cycles (1 ms at 50 MHz).
REQ-004 SHALL have port clk, input, 1, the single clock; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port reset, input, 1, the synchronous active-high reset.
REQ-006 SHALL have port keys_in, input, NKEYS, raw asynchronous key levels, 1 = pressed.
REQ-007 SHALL have port address, input, 3, the Avalon-MM word address.
REQ-008 SHALL have port chipselect, input, 1, the slave select.
REQ-009 SHALL have port write_n, input, 1, the active-low write strobe.
REQ-010 SHALL have port read_n, input, 1, the active-low read strobe.
REQ-011 SHALL have port writedata, input, 16, the write data.
REQ-012 SHALL have port readdata, output, 16, registered read data, latency 1.
REQ-013 SHALL have port irq, output, 1, the level interrupt to the CPU.

Function
REQ-014 SHALL synchronize keys_in through 2 flops before any use.
REQ-015 SHALL run a 16-bit tick down-counter:
  - at 0 it reloads PERIOD and issues a 1-cycle tick;
  - it runs only while CONTROL[1] (scan enable) = 1.
REQ-016 SHALL, on each tick, capture the synchronized keys into a sample register.
REQ-017 SHALL, on each tick, update a key's debounced bit only when the new sample equals the previous sample and differs from the debounced bit; every such bit is ORed into a pending-change mask.
REQ-018 SHALL, while the mask is non-zero, push one event per cycle for the lowest-index set bit and clear that bit.
REQ-019 SHALL format each event as [15] = 1, [8] = 1 for press / 0 for release, [3:0] = key index, all other bits 0.
REQ-020 SHALL clamp PERIOD writes below 32 to 32, so the mask always drains before the next tick.
REQ-021 SHALL, on a PERIOD write, reload the tick counter with the new value on the next cycle.
REQ-022 SHALL map registers as follows:
  - 0 STATUS (read): [0] = FIFO non-empty, [1] = overflow (sticky), [7:4] = count; a STATUS write of any value clears overflow.
  - 1 CONTROL (read/write, bits [1:0]): [0] = irq enable, [1] = scan enable.
  - 2 PERIOD (read/write).
  - 3 EVENT (read pops the FIFO).
  - 4 KEYS (read-only): debounced state.
  - 5 RAW (read-only): synchronized keys.
  - Addresses 6-7 read 0.
REQ-023 SHALL register readdata every cycle from the address mux, so data appears the cycle after the address is presented.
REQ-024 SHALL pop on an EVENT read only when the FIFO is non-empty; an EVENT read when empty SHALL return 0 and leave the FIFO unchanged.
REQ-025 SHALL, on a simultaneous push and pop, perform both:
  - when full, count stays DEPTH and overflow is not set;
  - when empty, the pop returns 0 and the push lands.
REQ-026 SHALL, on a push while full with no pop, drop the event and set overflow.
REQ-027 SHALL drive irq = CONTROL[0] & (non-empty | overflow), combinationally from registers.
REQ-028 SHALL, when scan enable is cleared, freeze the tick counter; already-pending mask bits still drain.

Reset
REQ-029 SHALL, on reset:
  - set readdata = 0, irq = 0, CONTROL = 0, PERIOD = DEFAULT_PERIOD, FIFO empty, overflow = 0;
  - set mask, samples, debounced state and synchronizers to 0;
  - set the tick counter to DEFAULT_PERIOD.
REQ-030 SHALL, on reset mid-operation, discard all queued and pending events within the same cycle.

Structure
REQ-031 SHALL place register address constants, CONTROL/STATUS bit positions, the event field layout and PERIOD_MIN = 32 in shared package key_scan_pkg.
REQ-032 SHALL implement the event queue as sub-module key_event_fifo, a synchronous 16-bit x DEPTH FIFO with count, full, empty and simultaneous push/pop support.

Verification
REQ-033 Press key 5, PERIOD = 32, scan enabled -> after 2 ticks, KEYS = 0x0020 and EVENT reads 0x8105, then STATUS = 0.
REQ-034 Glitch key 2 high for 20 cycles, PERIOD = 64 -> no event, KEYS = 0.
REQ-035 Press keys 0, 3 and 9 in the same cycle -> three events in order 0x8100, 0x8103, 0x8109, pushed on consecutive cycles.
REQ-036 Generate 9 events with no reads -> count = 8, STATUS[1] = 1, irq = 1 with CONTROL = 1; the 9th event is lost; a STATUS write clears overflow.
REQ-037 FIFO full, EVENT read in the same cycle as a new push -> count stays 8, overflow stays 0, and the oldest entry is returned.
REQ-038 Write PERIOD = 5 -> PERIOD reads 32; assert reset mid-drain -> FIFO empty, irq = 0, readdata = 0 next cycle.
